// File: rtl/attack_sequencer_if.sv
// rtl/attack_sequencer_if.sv - player request/status and hit-report bundle for attack_sequencer
// master drives tick/requests and observes results; slave is the sequencer side.
interface attack_sequencer_if;
   logic       gameTicks;
   logic [1:0] p1Combo;
   logic [1:0] p2Combo;
   logic       p1Stunned;
   logic       p2Stunned;
   logic       p1Blocking;
   logic       p2Blocking;
   logic       p1InRange;
   logic       p2InRange;
   logic       p1Attacking;
   logic       p2Attacking;
   logic [1:0] p1Phase;
   logic [1:0] p2Phase;
   logic       p1HitStrobe;
   logic       p2HitStrobe;
   logic [4:0] p1HitDamage;
   logic [4:0] p2HitDamage;
   logic       clashStrobe;

   modport master (
      output gameTicks, p1Combo, p2Combo, p1Stunned, p2Stunned,
             p1Blocking, p2Blocking, p1InRange, p2InRange,
      input  p1Attacking, p2Attacking, p1Phase, p2Phase,
             p1HitStrobe, p2HitStrobe, p1HitDamage, p2HitDamage, clashStrobe
   );

   modport slave (
      input  gameTicks, p1Combo, p2Combo, p1Stunned, p2Stunned,
             p1Blocking, p2Blocking, p1InRange, p2InRange,
      output p1Attacking, p2Attacking, p1Phase, p2Phase,
             p1HitStrobe, p2HitStrobe, p1HitDamage, p2HitDamage, clashStrobe
   );
endinterface

// File: rtl/attack_sequencer.sv
// rtl/attack_sequencer.sv - two-player STARTUP/ACTIVE/RECOVERY attack sequencer with hit/block/clash resolution
// Define CHIP_DAMAGE_EN to give blocked hits a quarter of the level damage.
module attack_sequencer #(
   parameter int STARTUP_L1   = 2,
   parameter int STARTUP_L2   = 3,
   parameter int STARTUP_L3   = 4,
   parameter int ACTIVE_TICKS = 2,
   parameter int RECOVER_L1   = 3,
   parameter int RECOVER_L2   = 5,
   parameter int RECOVER_L3   = 8,
   parameter int DMG_L1       = 5,
   parameter int DMG_L2       = 10,
   parameter int DMG_L3       = 20
) (
   input  logic               clk,
   input  logic               reset,
   attack_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STARTUP  = 2'd1,
      ACTIVE   = 2'd2,
      RECOVERY = 2'd3
   } phase_t;

   function automatic logic [7:0] dur(input int n);
      if (n < 1)   return 8'd1;
      if (n > 255) return 8'd255;
      return 8'(n);
   endfunction

   function automatic logic [4:0] sat5(input int n);
      if (n < 0)  return 5'd0;
      if (n > 31) return 5'd31;
      return 5'(n);
   endfunction

   localparam logic [7:0] C_ST1 = dur(STARTUP_L1);
   localparam logic [7:0] C_ST2 = dur(STARTUP_L2);
   localparam logic [7:0] C_ST3 = dur(STARTUP_L3);
   localparam logic [7:0] C_ACT = dur(ACTIVE_TICKS);
   localparam logic [7:0] C_RC1 = dur(RECOVER_L1);
   localparam logic [7:0] C_RC2 = dur(RECOVER_L2);
   localparam logic [7:0] C_RC3 = dur(RECOVER_L3);
   localparam logic [4:0] C_DM1 = sat5(DMG_L1);
   localparam logic [4:0] C_DM2 = sat5(DMG_L2);
   localparam logic [4:0] C_DM3 = sat5(DMG_L3);

   function automatic logic [7:0] startup_len(input logic [1:0] lvl);
      case (lvl)
         2'd1:    return C_ST1;
         2'd2:    return C_ST2;
         default: return C_ST3;
      endcase
   endfunction

   function automatic logic [7:0] recover_len(input logic [1:0] lvl);
      case (lvl)
         2'd1:    return C_RC1;
         2'd2:    return C_RC2;
         default: return C_RC3;
      endcase
   endfunction

   function automatic logic [4:0] damage_of(input logic [1:0] lvl);
      case (lvl)
         2'd1:    return C_DM1;
         2'd2:    return C_DM2;
         2'd3:    return C_DM3;
         default: return 5'd0;
      endcase
   endfunction

   logic       r_ticks_q;
   logic       r_clash;
   logic       w_tick;
   logic       w_both;
   logic       w_clash;
   logic [1:0] w_combo [2];
   logic       w_stun  [2];
   logic       w_blk   [2];
   logic       w_inr   [2];
   logic       w_enter [2];
   logic [1:0] w_level [2];
   phase_t     w_phase [2];
   logic       w_hit   [2];
   logic [4:0] w_dmg   [2];

   assign w_combo[0] = bus.p1Combo;
   assign w_combo[1] = bus.p2Combo;
   assign w_stun[0]  = bus.p1Stunned;
   assign w_stun[1]  = bus.p2Stunned;
   assign w_blk[0]   = bus.p1Blocking;
   assign w_blk[1]   = bus.p2Blocking;
   assign w_inr[0]   = bus.p1InRange;
   assign w_inr[1]   = bus.p2InRange;

   assign w_tick  = bus.gameTicks & ~r_ticks_q;
   // Only a mutual in-range entry is contested; otherwise each side resolves alone.
   assign w_both  = w_enter[0] & w_enter[1] & w_inr[0] & w_inr[1];
   assign w_clash = w_both & (w_level[0] == w_level[1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ticks_q <= 1'b0;
         r_clash   <= 1'b0;
      end else begin
         r_ticks_q <= bus.gameTicks;
         r_clash   <= w_clash;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_player
      localparam int O = 1 - g;

      phase_t     r_phase;
      logic [7:0] r_cnt;
      logic [1:0] r_level;
      logic       r_armed;
      logic       r_hit;
      logic [4:0] r_dmg;
      logic       w_skip;
      logic       w_hit_now;
      logic [4:0] w_full;
      logic [4:0] w_blocked;
      logic [4:0] w_dmg_now;

      assign w_enter[g] = w_tick & (r_phase == STARTUP) & ~w_stun[g] & (r_cnt == 8'd1);
      // Lower (or equal) level in a contested entry loses ACTIVE entirely.
      assign w_skip     = w_both & (r_level <= w_level[O]);
      assign w_hit_now  = w_enter[g] & w_inr[g] & ~w_skip;
      assign w_full     = damage_of(r_level);
`ifdef CHIP_DAMAGE_EN
      assign w_blocked  = w_full >> 2;
`else
      assign w_blocked  = 5'd0;
`endif
      assign w_dmg_now  = w_hit_now ? (w_blk[O] ? w_blocked : w_full) : 5'd0;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_phase <= IDLE;
            r_cnt   <= 8'd0;
            r_level <= 2'd0;
            r_armed <= 1'b1;
            r_hit   <= 1'b0;
            r_dmg   <= 5'd0;
         end else begin
            r_hit <= w_hit_now;
            r_dmg <= w_dmg_now;
            if (w_tick) begin
               case (r_phase)
                  IDLE: begin
                     if ((w_combo[g] != 2'd0) && !w_stun[g] && r_armed) begin
                        r_phase <= STARTUP;
                        r_cnt   <= startup_len(w_combo[g]);
                        r_level <= w_combo[g];
                        r_armed <= 1'b0;
                     end else if (w_combo[g] == 2'd0) begin
                        r_armed <= 1'b1;
                     end
                  end
                  STARTUP: begin
                     if (w_stun[g]) begin
                        r_phase <= IDLE;
                        r_cnt   <= 8'd0;
                     end else if (r_cnt <= 8'd1) begin
                        if (w_skip) begin
                           r_phase <= RECOVERY;
                           r_cnt   <= recover_len(r_level);
                        end else begin
                           r_phase <= ACTIVE;
                           r_cnt   <= C_ACT;
                        end
                     end else begin
                        r_cnt <= r_cnt - 8'd1;
                     end
                  end
                  ACTIVE: begin
                     if (r_cnt <= 8'd1) begin
                        r_phase <= RECOVERY;
                        r_cnt   <= recover_len(r_level);
                     end else begin
                        r_cnt <= r_cnt - 8'd1;
                     end
                  end
                  default: begin
                     if (r_cnt <= 8'd1) begin
                        r_phase <= IDLE;
                        r_cnt   <= 8'd0;
                     end else begin
                        r_cnt <= r_cnt - 8'd1;
                     end
                  end
               endcase
            end
         end
      end

      assign w_phase[g] = r_phase;
      assign w_level[g] = r_level;
      assign w_hit[g]   = r_hit;
      assign w_dmg[g]   = r_dmg;
   end

   assign bus.p1Phase     = w_phase[0];
   assign bus.p2Phase     = w_phase[1];
   assign bus.p1Attacking = (w_phase[0] != IDLE);
   assign bus.p2Attacking = (w_phase[1] != IDLE);
   assign bus.p1HitStrobe = w_hit[0];
   assign bus.p2HitStrobe = w_hit[1];
   assign bus.p1HitDamage = w_dmg[0];
   assign bus.p2HitDamage = w_dmg[1];
   assign bus.clashStrobe = r_clash;

endmodule
